// File: rtl/data_mem_stage_pkg.sv
// Shared definitions for the data memory stage: FSM encoding and RAM/register sizing.
package data_mem_stage_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    READ_WAIT = 1'b1
  } stateT;

  localparam int RAM_DEPTH = 64;
  localparam int RAM_IDX_W = 6;
  localparam int REG_IDX_W = 4;

endpackage

// File: rtl/data_mem_stage_ram.sv
// 64 x 32-bit data RAM with per-byte-lane write enables and a registered read port.
module data_ram
  import data_mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic [3:0]           byteEn,
  input  logic                 readEn,
  input  logic [RAM_IDX_W-1:0] index,
  input  logic [31:0]          wrData,
  output logic [31:0]          rdData
);

  logic [31:0] mem [RAM_DEPTH];

  // Contents are deliberately never reset so that data survives a pipeline reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) begin
        mem[index][i*8 +: 8] <= wrData[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (readEn) begin
      rdData <= mem[index];
    end
  end

endmodule

// File: rtl/data_mem_stage.sv
// Memory pipeline stage: single-cycle ALU/store pass-through, two-cycle loads with a one-cycle stall.
// Optional word-alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module data_mem_stage
  import data_mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 byte_sel,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [REG_IDX_W-1:0] rd_in,
  input  logic                 link_in,
  output logic                 stall_out,
  output logic                 out_valid,
  output logic [31:0]          dataMemOut,
  output logic [REG_IDX_W-1:0] rd_out,
  output logic                 link_out,
  output logic                 fault
);

  stateT                stateReg, stateNext;
  logic                 validReg, validNext;
  logic [31:0]          dataReg, dataNext;
  logic [REG_IDX_W-1:0] rdReg, rdNext;
  logic                 linkReg, linkNext;
  logic                 faultReg, faultNext;

  // Load context captured at E0 and consumed at E1.
  logic [1:0]           loadLaneReg, loadLaneNext;
  logic                 loadByteReg, loadByteNext;
  logic [REG_IDX_W-1:0] loadRdReg, loadRdNext;
  logic                 loadLinkReg, loadLinkNext;
  logic                 loadFaultReg, loadFaultNext;

  logic        misalign;
  logic        isLoad;
  logic        storeGo;
  logic [3:0]  byteEn;
  logic [31:0] ramWrData;
  logic [31:0] ramRdData;
  logic [7:0]  laneByte;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = !byte_sel && (addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign isLoad    = (stateReg == IDLE) && in_valid && mem_read;
  assign storeGo   = (stateReg == IDLE) && in_valid && !mem_read && mem_write && !misalign;
  assign byteEn    = !storeGo ? 4'b0000 : (byte_sel ? (4'b0001 << addr[1:0]) : 4'b1111);
  assign ramWrData = byte_sel ? {4{wdata[7:0]}} : wdata;
  assign laneByte  = ramRdData[{loadLaneReg, 3'b000} +: 8];
  assign stall_out = isLoad;

  data_ram uRam (
    .clk    (clk),
    .byteEn (byteEn),
    .readEn (isLoad),
    .index  (addr[RAM_IDX_W+1:2]),
    .wrData (ramWrData),
    .rdData (ramRdData)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg     <= IDLE;
      validReg     <= 1'b0;
      dataReg      <= '0;
      rdReg        <= '0;
      linkReg      <= 1'b0;
      faultReg     <= 1'b0;
      loadLaneReg  <= '0;
      loadByteReg  <= 1'b0;
      loadRdReg    <= '0;
      loadLinkReg  <= 1'b0;
      loadFaultReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      validReg     <= validNext;
      dataReg      <= dataNext;
      rdReg        <= rdNext;
      linkReg      <= linkNext;
      faultReg     <= faultNext;
      loadLaneReg  <= loadLaneNext;
      loadByteReg  <= loadByteNext;
      loadRdReg    <= loadRdNext;
      loadLinkReg  <= loadLinkNext;
      loadFaultReg <= loadFaultNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    validNext     = validReg;
    dataNext      = dataReg;
    rdNext        = rdReg;
    linkNext      = linkReg;
    faultNext     = faultReg;
    loadLaneNext  = loadLaneReg;
    loadByteNext  = loadByteReg;
    loadRdNext    = loadRdReg;
    loadLinkNext  = loadLinkReg;
    loadFaultNext = loadFaultReg;
    case (stateReg)
      IDLE: begin
        validNext = 1'b0;
        faultNext = 1'b0;
        if (in_valid && mem_read) begin
          loadLaneNext  = addr[1:0];
          loadByteNext  = byte_sel;
          loadRdNext    = rd_in;
          loadLinkNext  = link_in;
          loadFaultNext = misalign;
          stateNext     = READ_WAIT;
        end else if (in_valid) begin
          validNext = 1'b1;
          dataNext  = addr;
          rdNext    = rd_in;
          linkNext  = link_in;
          faultNext = misalign;
        end
      end
      READ_WAIT: begin
        validNext = 1'b1;
        if (loadFaultReg) begin
          dataNext = '0;
        end else if (loadByteReg) begin
          dataNext = {24'h000000, laneByte};
        end else begin
          dataNext = ramRdData;
        end
        rdNext    = loadRdReg;
        linkNext  = loadLinkReg;
        faultNext = loadFaultReg;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign out_valid  = validReg;
  assign dataMemOut = dataReg;
  assign rd_out     = rdReg;
  assign link_out   = linkReg;
  assign fault      = faultReg;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed self-checking bench for data_mem_stage; expectations follow MEM_ALIGN_CHECK_EN when defined.
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, mem_read, mem_write, byte_sel, link_in;
  logic [31:0] addr, wdata;
  logic [3:0]  rd_in;
  logic        stall_out, out_valid, link_out, fault;
  logic [31:0] dataMemOut;
  logic [3:0]  rd_out;

  int checks = 0;
  int errors = 0;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  data_mem_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .byte_sel   (byte_sel),
    .addr       (addr),
    .wdata      (wdata),
    .rd_in      (rd_in),
    .link_in    (link_in),
    .stall_out  (stall_out),
    .out_valid  (out_valid),
    .dataMemOut (dataMemOut),
    .rd_out     (rd_out),
    .link_out   (link_out),
    .fault      (fault)
  );

  // Non-load transaction: drives one cycle, returns the combinational stall seen before the edge.
  task automatic issue_op(input logic wr, input logic bs, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] rdi, input logic lk,
                          output logic stallSeen);
    in_valid = 1'b1; mem_read = 1'b0; mem_write = wr; byte_sel = bs;
    addr = a; wdata = wd; rd_in = rdi; link_in = lk;
    #1 stallSeen = stall_out;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_write = 1'b0;
    $display("txn op   wr=%0b byte=%0b addr=%h wdata=%h -> valid=%0b data=%h fault=%0b",
             wr, bs, a, wd, out_valid, dataMemOut, fault);
  endtask

  // Load transaction through E0 and E1; captures observations for the caller to compare.
  task automatic issue_load(input logic wr, input logic bs, input logic [31:0] a,
                            input logic [3:0] rdi, input logic lk,
                            output logic stallSeen, output logic validE0,
                            output logic [31:0] data, output logic validE1,
                            output logic [3:0] rdo, output logic flt);
    in_valid = 1'b1; mem_read = 1'b1; mem_write = wr; byte_sel = bs;
    addr = a; wdata = 32'h55555555; rd_in = rdi; link_in = lk;
    #1 stallSeen = stall_out;
    @(posedge clk); #1;
    validE0 = out_valid;
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    validE1 = out_valid; data = dataMemOut; rdo = rd_out; flt = fault;
    $display("txn load byte=%0b addr=%h -> valid=%0b data=%h rd=%0d fault=%0b",
             bs, a, validE1, data, rdo, flt);
  endtask

  task automatic test_reset();
    checks++; if ({out_valid, dataMemOut, rd_out, link_out, fault} !== 39'd0) begin
      errors++; $display("FAIL reset_outputs got v=%0b d=%h rd=%0d l=%0b f=%0b want all 0",
                         out_valid, dataMemOut, rd_out, link_out, fault); end
    in_valid = 1'b1; mem_read = 1'b1; #1;
    checks++; if (stall_out !== 1'b1) begin
      errors++; $display("FAIL reset_stall got %0b want 1", stall_out); end
    in_valid = 1'b0; mem_read = 1'b0; #1;
    checks++; if (stall_out !== 1'b0) begin
      errors++; $display("FAIL reset_stall_idle got %0b want 0", stall_out); end
  endtask

  task automatic test_word_store_load();
    logic s, v0, v1, f; logic [31:0] d; logic [3:0] r;
    issue_op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'd1, 1'b0, s);
    checks++; if (s !== 1'b0 || out_valid !== 1'b1 || dataMemOut !== 32'h10) begin
      errors++; $display("FAIL store_pass got s=%0b v=%0b d=%h want s=0 v=1 d=00000010", s, out_valid, dataMemOut); end
    issue_load(1'b0, 1'b0, 32'h10, 4'd5, 1'b0, s, v0, d, v1, r, f);
    checks++; if (s !== 1'b1 || v0 !== 1'b0) begin
      errors++; $display("FAIL load_stall got stall=%0b validE0=%0b want 1 0", s, v0); end
    checks++; if (v1 !== 1'b1 || d !== 32'hDEADBEEF || r !== 4'd5) begin
      errors++; $display("FAIL load_data got v=%0b d=%h rd=%0d want 1 deadbeef 5", v1, d, r); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || dataMemOut !== 32'hDEADBEEF) begin
      errors++; $display("FAIL idle_hold got v=%0b d=%h want 0 deadbeef", out_valid, dataMemOut); end
  endtask

  task automatic test_byte();
    logic s, v0, v1, f; logic [31:0] d; logic [3:0] r;
    issue_op(1'b1, 1'b0, 32'h10, 32'h11223344, 4'd0, 1'b0, s);
    issue_op(1'b1, 1'b1, 32'h13, 32'hFFFFFFAB, 4'd0, 1'b0, s);
    checks++; if (fault !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL byte_store_nofault got v=%0b f=%0b want 1 0", out_valid, fault); end
    issue_load(1'b0, 1'b0, 32'h10, 4'd2, 1'b0, s, v0, d, v1, r, f);
    checks++; if (d !== 32'hAB223344) begin
      errors++; $display("FAIL byte_merge got %h want ab223344", d); end
    issue_load(1'b0, 1'b1, 32'h13, 4'd3, 1'b0, s, v0, d, v1, r, f);
    checks++; if (d !== 32'h000000AB || v1 !== 1'b1) begin
      errors++; $display("FAIL byte_load3 got %h want 000000ab", d); end
    issue_load(1'b0, 1'b1, 32'h11, 4'd3, 1'b0, s, v0, d, v1, r, f);
    checks++; if (d !== 32'h00000033 || f !== 1'b0) begin
      errors++; $display("FAIL byte_load1 got %h f=%0b want 00000033 0", d, f); end
  endtask

  task automatic test_alu();
    logic s;
    issue_op(1'b0, 1'b0, 32'h00001234, 32'h0, 4'd7, 1'b1, s);
    checks++; if (s !== 1'b0 || out_valid !== 1'b1 || dataMemOut !== 32'h00001234 ||
                  link_out !== 1'b1 || rd_out !== 4'd7) begin
      errors++; $display("FAIL alu got s=%0b v=%0b d=%h l=%0b rd=%0d want 0 1 00001234 1 7",
                         s, out_valid, dataMemOut, link_out, rd_out); end
  endtask

  task automatic test_reset_in_wait();
    logic s, v0, v1, f; logic [31:0] d; logic [3:0] r;
    in_valid = 1'b1; mem_read = 1'b1; byte_sel = 1'b0; addr = 32'h10; rd_in = 4'd9; link_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_read = 1'b0;
    reset = 1'b1; #1;
    checks++; if ({out_valid, dataMemOut, rd_out, link_out} !== 38'd0) begin
      errors++; $display("FAIL async_reset got v=%0b d=%h rd=%0d l=%0b want 0", out_valid, dataMemOut, rd_out, link_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_no_valid got %0b want 0", out_valid); end
    issue_load(1'b0, 1'b0, 32'h10, 4'd4, 1'b0, s, v0, d, v1, r, f);
    checks++; if (d !== 32'hAB223344 || v1 !== 1'b1) begin
      errors++; $display("FAIL ram_survives_reset got %h want ab223344", d); end
  endtask

  task automatic test_read_write_both();
    logic s, v0, v1, f; logic [31:0] d; logic [3:0] r;
    issue_load(1'b1, 1'b0, 32'h10, 4'd6, 1'b0, s, v0, d, v1, r, f);
    checks++; if (s !== 1'b1 || d !== 32'hAB223344) begin
      errors++; $display("FAIL rw_as_load got s=%0b d=%h want 1 ab223344", s, d); end
    issue_load(1'b0, 1'b0, 32'h10, 4'd6, 1'b0, s, v0, d, v1, r, f);
    checks++; if (d !== 32'hAB223344) begin
      errors++; $display("FAIL rw_no_write got %h want ab223344", d); end
  endtask

  task automatic test_wrap();
    logic s, v0, v1, f; logic [31:0] d; logic [3:0] r;
    issue_op(1'b1, 1'b0, 32'h10, 32'h0BADC0DE, 4'd0, 1'b0, s);
    issue_load(1'b0, 1'b0, 32'h110, 4'd8, 1'b0, s, v0, d, v1, r, f);
    checks++; if (d !== 32'h0BADC0DE || r !== 4'd8) begin
      errors++; $display("FAIL wrap got d=%h rd=%0d want 0badc0de 8", d, r); end
  endtask

  task automatic test_align();
    logic s, v0, v1, f; logic [31:0] d, expData; logic [3:0] r;
    issue_op(1'b1, 1'b0, 32'h10, 32'h11223344, 4'd0, 1'b0, s);
    issue_op(1'b1, 1'b0, 32'h12, 32'hFFFFFFFF, 4'd0, 1'b0, s);
    checks++; if (out_valid !== 1'b1 || fault !== ALIGN_EN) begin
      errors++; $display("FAIL align_store_fault got v=%0b f=%0b want 1 %0b", out_valid, fault, ALIGN_EN); end
    @(posedge clk); #1;
    checks++; if (fault !== 1'b0) begin
      errors++; $display("FAIL align_fault_pulse got %0b want 0", fault); end
    expData = ALIGN_EN ? 32'h11223344 : 32'hFFFFFFFF;
    issue_load(1'b0, 1'b0, 32'h10, 4'd1, 1'b0, s, v0, d, v1, r, f);
    checks++; if (d !== expData || f !== 1'b0) begin
      errors++; $display("FAIL align_ram got d=%h f=%0b want %h 0", d, f, expData); end
    expData = ALIGN_EN ? 32'h0 : 32'hFFFFFFFF;
    issue_load(1'b0, 1'b0, 32'h12, 4'd1, 1'b0, s, v0, d, v1, r, f);
    checks++; if (d !== expData || f !== ALIGN_EN || v1 !== 1'b1) begin
      errors++; $display("FAIL align_load got d=%h f=%0b want %h %0b", d, f, expData, ALIGN_EN); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; byte_sel = 1'b0;
    addr = '0; wdata = '0; rd_in = '0; link_in = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_word_store_load();
    test_byte();
    test_alu();
    test_reset_in_wait();
    test_read_write_both();
    test_wrap();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without completing");
    $fatal(1);
  end

endmodule
